sa_data_feeder: RTL and testbench

- Activation-side loader for the 3x3 systolic array; it is the stage downstream of the weight preloader.
- Triggered by the preloader's completion pulse, it reads a 3xK input matrix from the shared 8-bit synchronous memory into a local buffer.
- It then streams the matrix into the three SA rows at full rate, each row delayed one cycle from the row above (diagonal skew).
- It signals completion after the last element leaves.

---
 rtl/sa_pkg.sv | 17 +
 rtl/sa_input_buffer.sv | 38 +++
 rtl/sa_data_feeder.sv | 121 ++++++++++++
 tb/tb_sa_data_feeder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the 3x3 systolic array loaders: array geometry,
// memory map and the feeder FSM state encoding.
package sa_pkg;

  localparam int SA_DIM      = 3;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 6;
  localparam int WEIGHT_BASE = 0;
  localparam int ACT_BASE    = 9;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_LOAD_WAIT = 3'd2;
  localparam logic [2:0] ST_STREAM    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/sa_input_buffer.sv
// 3xK activation register file: linear write port from the loader and three
// skewed read ports, one per SA row, each with its own in-range valid.
module sa_input_buffer #(
  parameter int DATA_W  = 8,
  parameter int NUM_VEC = 3,
  parameter int IDX_W   = $clog2(3 * NUM_VEC),
  parameter int CNT_W   = $clog2(NUM_VEC + 3)
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [IDX_W-1:0]                      wr_idx,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic                                  rd_en,
  input  logic [CNT_W-1:0]                      rd_cnt,
  output logic [sa_pkg::SA_DIM-1:0][DATA_W-1:0] rd_data,
  output logic [sa_pkg::SA_DIM-1:0]             rd_vld
);
  import sa_pkg::*;

  logic [DATA_W-1:0] mem [SA_DIM * NUM_VEC];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Row r reads column rd_cnt-r; outside 0..K-1 the row is idle and reads 0.
  always_comb begin
    rd_data = '0;
    rd_vld  = '0;
    for (int r = 0; r < SA_DIM; r++) begin
      if (rd_en && int'(rd_cnt) >= r && (int'(rd_cnt) - r) < NUM_VEC) begin
        rd_vld[r]  = 1'b1;
        rd_data[r] = mem[IDX_W'(r * NUM_VEC + int'(rd_cnt) - r)];
      end
    end
  end

endmodule

// File: rtl/sa_data_feeder.sv
// Activation loader for the 3x3 SA: on start, copies the 3xK input matrix from
// shared memory into a local buffer, then streams it diagonally skewed into the rows.
module sa_data_feeder #(
  parameter int DATA_W    = sa_pkg::DATA_W,
  parameter int ADDR_W    = sa_pkg::ADDR_W,
  parameter int BASE_ADDR = sa_pkg::ACT_BASE,
  parameter int NUM_VEC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_row0,
  output logic [DATA_W-1:0] data_row1,
  output logic [DATA_W-1:0] data_row2,
  output logic              valid_row0,
  output logic              valid_row1,
  output logic              valid_row2,
  output logic              busy,
  output logic              is_done_o
);
  import sa_pkg::*;

  localparam int LD_N = SA_DIM * NUM_VEC;
  localparam int LD_W = $clog2(LD_N);
  localparam int SC_W = $clog2(NUM_VEC + 2);
  localparam int PT_W = $clog2(NUM_VEC + 3);

  logic [2:0]       state;
  logic [LD_W-1:0]  load_idx;
  logic [SC_W-1:0]  stream_cnt;
  logic             ld_vld_p0;
  logic [LD_W-1:0]  ld_idx_p0;
  logic             rd_en;
  logic [PT_W-1:0]  rd_cnt;
  logic [SA_DIM-1:0][DATA_W-1:0] rd_data;
  logic [SA_DIM-1:0]             rd_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      load_idx   <= '0;
      stream_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          load_idx <= '0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (load_idx == LD_W'(LD_N - 1)) state <= ST_LOAD_WAIT;
          else load_idx <= load_idx + LD_W'(1);
        end
        ST_LOAD_WAIT: begin
          stream_cnt <= '0;
          state      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (stream_cnt == SC_W'(NUM_VEC + 1)) state <= ST_DONE;
          else stream_cnt <= stream_cnt + SC_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign addr      = (state == ST_LOAD) ? ADDR_W'(BASE_ADDR) + ADDR_W'(load_idx) : '0;
  assign busy      = (state != ST_IDLE);
  assign is_done_o = (state == ST_DONE);

  // p0: read data returns one cycle after addr; write it to the slot issued then
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ld_vld_p0 <= 1'b0;
    else      ld_vld_p0 <= (state == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    ld_idx_p0 <= load_idx;
  end

  // The register stage below adds a cycle, so reading starts in LOAD_WAIT.
  assign rd_en  = (state == ST_LOAD_WAIT) || (state == ST_STREAM);
  assign rd_cnt = (state == ST_STREAM) ? PT_W'(stream_cnt) + PT_W'(1) : '0;

  sa_input_buffer #(
    .DATA_W  (DATA_W),
    .NUM_VEC (NUM_VEC),
    .IDX_W   (LD_W),
    .CNT_W   (PT_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (ld_vld_p0),
    .wr_idx  (ld_idx_p0),
    .wr_data (q),
    .rd_en   (rd_en),
    .rd_cnt  (rd_cnt),
    .rd_data (rd_data),
    .rd_vld  (rd_vld)
  );

  // p1: registered row outputs; idle rows carry zero data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_row0 <= 1'b0;
      valid_row1 <= 1'b0;
      valid_row2 <= 1'b0;
      data_row0  <= '0;
      data_row1  <= '0;
      data_row2  <= '0;
    end else begin
      valid_row0 <= rd_vld[0];
      valid_row1 <= rd_vld[1];
      valid_row2 <= rd_vld[2];
      data_row0  <= rd_data[0];
      data_row1  <= rd_data[1];
      data_row2  <= rd_data[2];
    end
  end

endmodule

// File: tb/tb_sa_data_feeder.sv
// Directed bench for sa_data_feeder: three instances (K=3, K=1, K=18), each
// with its own 1-cycle-latency memory model.
module tb_sa_data_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [3];
  logic [7:0] q     [3];
  logic [5:0] addr  [3];
  logic [7:0] drow  [3][3];
  logic       vrow  [3][3];
  logic       busy  [3];
  logic       done  [3];
  logic [7:0] mem   [3][64];
  bit         q_rand;
  int         checks;
  int         failures;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) q[i] <= q_rand ? 8'($urandom) : mem[i][addr[i]];
  end

  sa_data_feeder #(.NUM_VEC(3)) u_k3 (
    .clk(clk), .rst(rst), .start(start[0]), .q(q[0]), .addr(addr[0]),
    .data_row0(drow[0][0]), .data_row1(drow[0][1]), .data_row2(drow[0][2]),
    .valid_row0(vrow[0][0]), .valid_row1(vrow[0][1]), .valid_row2(vrow[0][2]),
    .busy(busy[0]), .is_done_o(done[0]));

  sa_data_feeder #(.NUM_VEC(1)) u_k1 (
    .clk(clk), .rst(rst), .start(start[1]), .q(q[1]), .addr(addr[1]),
    .data_row0(drow[1][0]), .data_row1(drow[1][1]), .data_row2(drow[1][2]),
    .valid_row0(vrow[1][0]), .valid_row1(vrow[1][1]), .valid_row2(vrow[1][2]),
    .busy(busy[1]), .is_done_o(done[1]));

  sa_data_feeder #(.NUM_VEC(18)) u_k18 (
    .clk(clk), .rst(rst), .start(start[2]), .q(q[2]), .addr(addr[2]),
    .data_row0(drow[2][0]), .data_row1(drow[2][1]), .data_row2(drow[2][2]),
    .valid_row0(vrow[2][0]), .valid_row1(vrow[2][1]), .valid_row2(vrow[2][2]),
    .busy(busy[2]), .is_done_o(done[2]));

  function automatic int kval(input int inst);
    return (inst == 0) ? 3 : (inst == 1) ? 1 : 18;
  endfunction

  function automatic logic [34:0] snap(input int i);
    return {addr[i], busy[i], done[i], vrow[i][0], vrow[i][1], vrow[i][2],
            drow[i][0], drow[i][1], drow[i][2]};
  endfunction

  task automatic test_reset();
    rst    = 1'b0;
    q_rand = 1'b1;
    for (int i = 0; i < 3; i++) start[i] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (snap(i) !== '0) begin
          failures++;
          $display("FAIL reset_hold inst=%0d outputs got %h want 0", i, snap(i));
        end
      end
    end
    @(posedge clk); #1;
    rst    = 1'b1;
    q_rand = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (snap(i) !== '0) begin
          failures++;
          $display("FAIL reset_release inst=%0d outputs got %h want 0", i, snap(i));
        end
      end
    end
  endtask

  // One full run on instance inst starting at cycle S = first loop iteration.
  task automatic test_run(input int inst, input string name, input bit ignore, input bit hold);
    int K, last, jj, k, per;
    logic [5:0] ea;
    logic       eb, ed, ev;
    logic [7:0] edat;
    K    = kval(inst);
    per  = 4 * K + 5;
    last = hold ? 2 * per + 1 : 4 * K + 6;
    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      start[inst] = hold ? (j <= per) : (j == 0 || (ignore && (j == 4 || j == 4 * K + 2)));
      @(negedge clk);
      jj = (hold && j >= per) ? j - per : j;
      ea = (jj >= 1 && jj <= 3 * K) ? 6'(8 + jj) : 6'd0;
      eb = (jj >= 1 && jj <= 4 * K + 4);
      ed = (jj == 4 * K + 4);
      checks++;
      if (addr[inst] !== ea) begin
        failures++;
        $display("FAIL %s addr j=%0d got %0d want %0d", name, j, addr[inst], ea);
      end
      checks++;
      if (busy[inst] !== eb) begin
        failures++;
        $display("FAIL %s busy j=%0d got %b want %b", name, j, busy[inst], eb);
      end
      checks++;
      if (done[inst] !== ed) begin
        failures++;
        $display("FAIL %s is_done_o j=%0d got %b want %b", name, j, done[inst], ed);
      end
      for (int r = 0; r < 3; r++) begin
        k    = jj - (3 * K + 2) - r;
        ev   = (k >= 0 && k < K);
        edat = ev ? mem[inst][9 + r * K + k] : 8'h00;
        checks++;
        if (vrow[inst][r] !== ev || drow[inst][r] !== edat) begin
          failures++;
          $display("FAIL %s row%0d j=%0d got v=%b d=%h want v=%b d=%h",
                   name, r, j, vrow[inst][r], drow[inst][r], ev, edat);
        end
      end
    end
    @(posedge clk); #1;
    start[inst] = 1'b0;
  endtask

  task automatic test_nominal();
    test_run(0, "nominal_k3", 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    test_run(0, "ignore_start", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_run(0, "back_to_back", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    start[0] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    checks++;
    if (addr[0] !== 6'd13) begin
      failures++;
      $display("FAIL abort_pre addr got %0d want 13", addr[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (snap(0) !== '0) begin
      failures++;
      $display("FAIL abort_immediate outputs got %h want 0", snap(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (snap(0) !== '0) begin
        failures++;
        $display("FAIL abort_hold outputs got %h want 0", snap(0));
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (snap(0) !== '0 ) begin
        failures++;
        $display("FAIL abort_after outputs got %h want 0", snap(0));
      end
    end
    test_run(0, "abort_rerun", 1'b0, 1'b0);
  endtask

  task automatic test_k1();
    test_run(1, "edge_k1", 1'b0, 1'b0);
  endtask

  task automatic test_k18();
    test_run(2, "max_k18", 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      for (int a = 0; a < 64; a++) mem[i][a] = 8'hEE;
    end
    for (int i = 0; i < 9; i++)  mem[0][9 + i] = 8'(8'h10 + i);
    mem[1][9]  = 8'hFF;
    mem[1][10] = 8'h00;
    mem[1][11] = 8'hA5;
    for (int i = 0; i < 54; i++) mem[2][9 + i] = 8'(i + 1);

    test_reset();
    test_nominal();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_k1();
    test_k18();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
